param_acc_cpu: RTL and testbench
================================

PARAM_ACC_CPU -- requirements
Module: param_acc_cpu

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8: accumulator/register/ALU width; legal values 8..32.
REQ-002 The module SHALL have parameter NREGS, default 16: register-file depth; power of two, 2..16.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port instr, input, 8 bits: instruction or immediate byte.
REQ-006 The module SHALL have port instr_valid, input, 1 bit: instr holds a valid byte.
REQ-007 The module SHALL have port instr_ready, output, 1 bit: the core accepts a byte this cycle.
REQ-008 The module SHALL have port acc_out, output, DATA_W bits: current accumulator value.
REQ-009 The module SHALL have ports carry and zero, outputs, 1 bit each: ALU flags.
REQ-010 The module SHALL have port halted, output, 1 bit: the core is in HALT.

Function
REQ-011 The core SHALL decode an instruction byte as opcode = instr[7:4] and operand n = instr[3:0]; register index = n modulo NREGS.
REQ-012 A byte SHALL transfer only on a cycle where instr_valid and instr_ready are both 1; instr_ready SHALL be 1 exactly in FETCH and IMM.
REQ-013 The FSM SHALL use states FETCH, EXEC, IMM and HALT: FETCH->EXEC on transfer, or FETCH->IMM if opcode is 0x8; EXEC->FETCH always; IMM->FETCH on transfer; FETCH->HALT on opcode 0xF.
REQ-014 The core SHALL hold its state in FETCH/IMM while no transfer occurs; an accepted byte SHALL be captured into an internal instruction register.
REQ-015 In EXEC, the core SHALL execute: 0x1 ADD acc+=R[n]; 0x2 SUB acc-=R[n]; 0x3 AND; 0x4 OR; 0x5 XOR; 0x6 R[n]<=acc; 0x7 acc<=R[n]; 0x9 SHL acc; 0xA SHR acc (logical).
REQ-016 For LDI (0x8), the immediate byte accepted in IMM SHALL be zero-extended to DATA_W and written to acc on the transfer edge.
REQ-017 The core SHALL treat opcode 0x0, undefined opcodes and 0xB-0xE as NOPs: one EXEC cycle, no state change.
REQ-018 ADD SHALL set carry to the carry-out at bit DATA_W, SUB SHALL set carry to the borrow, and SHL/SHR SHALL set carry to the bit shifted out; all arithmetic SHALL wrap modulo 2^DATA_W.
REQ-019 Every operation that writes acc SHALL set zero = (new acc == 0); logic ops, MOVR and LDI SHALL leave carry unchanged; MOVA and NOP SHALL leave both flags unchanged.
REQ-020 HALT SHALL be sticky: halted=1, instr_ready=0, inputs ignored, until reset.
REQ-021 Throughput SHALL be 2 cycles per non-LDI instruction and 2 transfers plus 0 EXEC cycles for LDI, with back-to-back valid data.

Reset
REQ-022 While reset=1, the core SHALL clear acc, all R[i], carry, zero and halted, set state to FETCH, and drive instr_ready=0.
REQ-023 Reset SHALL take priority in any state, including mid-LDI in IMM; the pending immediate SHALL be discarded; instr_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-024 When PARAM_ACC_CPU_MUL_EN is defined, opcode 0xC SHALL execute MUL: acc <= low DATA_W bits of acc*R[n], carry <= OR of high DATA_W bits, zero updated.
REQ-025 When PARAM_ACC_CPU_MUL_EN is undefined, opcode 0xC SHALL be a NOP and no multiplier SHALL be synthesised.

Structure
REQ-026 The shared package param_acc_cpu_pkg SHALL hold the opcode enum (4-bit) and the FSM state enum.
REQ-027 A single combinational sub-module acc_alu, parameterised by DATA_W, SHALL compute the result, carry and zero; the FSM, IR and register file SHALL be in param_acc_cpu.

Verification (DATA_W=8, NREGS=16)
REQ-028 The bench SHALL cover: reset held 3 cycles -> acc_out=0x00, carry=0, zero=0, instr_ready=0; then ready=1 on the next cycle.
REQ-029 The bench SHALL cover: 0x80,0xFF,0x63,0x80,0x01,0x13 -> R3=0xFF, acc_out=0x00, carry=1, zero=1.
REQ-030 The bench SHALL cover: acc=0x05, R1=0x07, 0x21 -> acc_out=0xFE, carry=1, zero=0; then 0xA0 -> acc_out=0x7F, carry=0.
REQ-031 The bench SHALL cover: 0x80 accepted, instr_valid low 5 cycles in IMM -> acc unchanged, ready=1 held; reset pulse then 0x7A -> ready high, acc=0x00, immediate dropped.
REQ-032 The bench SHALL cover: 0xF0 -> halted=1 next cycle, instr_ready=0; 0x80,0x55 offered -> ignored; reset clears halted.
REQ-033 The bench SHALL cover: with MUL_EN, acc=0x10, R2=0x20, 0xC2 -> acc_out=0x00, carry=1, zero=1; without MUL_EN, acc stays 0x10.

Source files
------------

// File: rtl/param_acc_cpu_pkg.sv
// Shared opcode and FSM state encodings for the param_acc_cpu accumulator core.
package param_acc_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_MOVA = 4'h6,
        OP_MOVR = 4'h7,
        OP_LDI  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_MUL  = 4'hC,
        OP_HALT = 4'hF
    } opcodeT;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IMM   = 2'd2,
        ST_HALT  = 2'd3
    } stateT;

endpackage

// File: rtl/param_acc_cpu_alu.sv
// Combinational ALU for the accumulator core; flags pass through when acc is not written.
// Optional multiply is enabled by defining PARAM_ACC_CPU_MUL_EN.
module acc_alu
    import param_acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carryIn,
    input  logic              zeroIn,
    output logic [DATA_W-1:0] result,
    output logic              carryOut,
    output logic              zeroOut
);

    logic [DATA_W:0] wide;
    logic            accWrite;
`ifdef PARAM_ACC_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    always_comb begin
        result   = a;
        carryOut = carryIn;
        zeroOut  = zeroIn;
        accWrite = 1'b0;
        wide     = '0;
`ifdef PARAM_ACC_CPU_MUL_EN
        prod     = '0;
`endif
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[DATA_W-1:0];
                carryOut = wide[DATA_W];
                accWrite = 1'b1;
            end
            // Bit DATA_W of the extended difference is the borrow.
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[DATA_W-1:0];
                carryOut = wide[DATA_W];
                accWrite = 1'b1;
            end
            OP_AND: begin
                result   = a & b;
                accWrite = 1'b1;
            end
            OP_OR: begin
                result   = a | b;
                accWrite = 1'b1;
            end
            OP_XOR: begin
                result   = a ^ b;
                accWrite = 1'b1;
            end
            OP_MOVR, OP_LDI: begin
                result   = b;
                accWrite = 1'b1;
            end
            OP_SHL: begin
                result   = {a[DATA_W-2:0], 1'b0};
                carryOut = a[DATA_W-1];
                accWrite = 1'b1;
            end
            OP_SHR: begin
                result   = {1'b0, a[DATA_W-1:1]};
                carryOut = a[0];
                accWrite = 1'b1;
            end
`ifdef PARAM_ACC_CPU_MUL_EN
            OP_MUL: begin
                prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                result   = prod[DATA_W-1:0];
                carryOut = |prod[2*DATA_W-1:DATA_W];
                accWrite = 1'b1;
            end
`endif
            default: ;
        endcase
        if (accWrite) zeroOut = (result == '0);
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Byte-fed accumulator core: FSM, instruction register and register file around acc_alu.
// Build option: define PARAM_ACC_CPU_MUL_EN to turn opcode 0xC into MUL.
//
// state    | meaning
// ST_FETCH | waiting for an instruction byte
// ST_EXEC  | executing the captured instruction (one cycle)
// ST_IMM   | waiting for the LDI immediate byte
// ST_HALT  | stopped until reset
module param_acc_cpu
    import param_acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry,
    output logic              zero,
    output logic              halted
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    stateT             state, nextState;
    logic [7:0]        ir;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regFile [NREGS];
    logic [IDX_W-1:0]  regIdx;
    logic              xfer;
    logic              accUpdate;
    logic [3:0]        aluOp;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;
    logic              aluZero;

    assign instr_ready = !reset && ((state == ST_FETCH) || (state == ST_IMM));
    assign xfer        = instr_valid && instr_ready;
    assign regIdx      = ir[IDX_W-1:0];
    assign acc_out     = acc;
    assign halted      = (state == ST_HALT);

    // LDI reuses the ALU move path with the immediate byte as operand.
    assign aluOp     = (state == ST_IMM) ? OP_LDI : ir[7:4];
    assign aluB      = (state == ST_IMM) ? DATA_W'(instr) : regFile[regIdx];
    assign accUpdate = (state == ST_EXEC) || ((state == ST_IMM) && xfer);

    acc_alu #(.DATA_W(DATA_W)) uAlu (
        .op       (aluOp),
        .a        (acc),
        .b        (aluB),
        .carryIn  (carry),
        .zeroIn   (zero),
        .result   (aluResult),
        .carryOut (aluCarry),
        .zeroOut  (aluZero)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_FETCH: begin
                if (xfer) begin
                    if (instr[7:4] == OP_LDI)       nextState = ST_IMM;
                    else if (instr[7:4] == OP_HALT) nextState = ST_HALT;
                    else                            nextState = ST_EXEC;
                end
            end
            ST_EXEC:  nextState = ST_FETCH;
            ST_IMM:   if (xfer) nextState = ST_FETCH;
            ST_HALT:  nextState = ST_HALT;
            default:  nextState = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            ir    <= '0;
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
        end else begin
            if ((state == ST_FETCH) && xfer) ir <= instr;
            if (accUpdate) begin
                acc   <= aluResult;
                carry <= aluCarry;
                zero  <= aluZero;
            end
            if ((state == ST_EXEC) && (ir[7:4] == OP_MOVA)) regFile[regIdx] <= acc;
        end
    end

endmodule

// File: tb/tb_param_acc_cpu.sv
// Directed self-checking bench for param_acc_cpu (DATA_W=8, NREGS=16).
module tb_param_acc_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] acc_out;
    logic       carry;
    logic       zero;
    logic       halted;

    int checks   = 0;
    int failures = 0;

    param_acc_cpu #(.DATA_W(8), .NREGS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .acc_out     (acc_out),
        .carry       (carry),
        .zero        (zero),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int cnt = 0;
        @(negedge clk);
        instr       = b;
        instr_valid = 1'b1;
        while (!instr_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("send_timeout", (cnt < 20), 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // Two falling edges: the EXEC edge (if any) has passed and the core is back in FETCH.
    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc",   acc_out,     8'h00);
        check("rst_carry", carry,       1'b0);
        check("rst_zero",  zero,        1'b0);
        check("rst_ready", instr_ready, 1'b0);
        check("rst_halt",  halted,      1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", instr_ready, 1'b1);

        // LDI FF, MOVA R3, LDI 01, ADD R3 -> wrap to zero with carry
        sendByte(8'h80); sendByte(8'hFF);
        settle();
        check("ldi_ff_acc",  acc_out, 8'hFF);
        check("ldi_ff_zero", zero,    1'b0);
        sendByte(8'h63);
        sendByte(8'h80); sendByte(8'h01);
        sendByte(8'h13);
        settle();
        check("add_acc",   acc_out, 8'h00);
        check("add_carry", carry,   1'b1);
        check("add_zero",  zero,    1'b1);
        sendByte(8'h73);
        settle();
        check("movr_r3_acc",   acc_out, 8'hFF);
        check("movr_r3_carry", carry,   1'b1);
        check("movr_r3_zero",  zero,    1'b0);

        // SUB with borrow, then SHR
        sendByte(8'h80); sendByte(8'h07);
        sendByte(8'h61);
        sendByte(8'h80); sendByte(8'h05);
        sendByte(8'h21);
        settle();
        check("sub_acc",   acc_out, 8'hFE);
        check("sub_carry", carry,   1'b1);
        check("sub_zero",  zero,    1'b0);
        sendByte(8'hA0);
        settle();
        check("shr_acc",   acc_out, 8'h7F);
        check("shr_carry", carry,   1'b0);

        // SHL, AND, OR, XOR, NOP against R1=07
        sendByte(8'h90);
        settle();
        check("shl_acc",   acc_out, 8'hFE);
        check("shl_carry", carry,   1'b0);
        sendByte(8'h31);
        settle();
        check("and_acc", acc_out, 8'h06);
        sendByte(8'h41);
        settle();
        check("or_acc", acc_out, 8'h07);
        sendByte(8'hB5);
        settle();
        check("nop_acc",  acc_out, 8'h07);
        check("nop_zero", zero,    1'b0);
        sendByte(8'h51);
        settle();
        check("xor_acc",   acc_out, 8'h00);
        check("xor_zero",  zero,    1'b1);
        check("xor_carry", carry,   1'b0);

        // LDI stalled in IMM, then reset discards the immediate
        sendByte(8'h80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("imm_wait_ready", instr_ready, 1'b1);
            check("imm_wait_acc",   acc_out,     8'h00);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("imm_rst_ready", instr_ready, 1'b1);
        sendByte(8'h7A);
        settle();
        check("imm_drop_acc",  acc_out, 8'h00);
        check("imm_drop_zero", zero,    1'b1);

        // HALT is sticky until reset
        sendByte(8'h80); sendByte(8'h33);
        sendByte(8'hF0);
        @(negedge clk);
        check("halt_flag",  halted,      1'b1);
        check("halt_ready", instr_ready, 1'b0);
        instr       = 8'h80;
        instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        instr = 8'h55;
        repeat (3) @(negedge clk);
        check("halt_acc",      acc_out, 8'h33);
        check("halt_sticky",   halted,  1'b1);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("halt_clr",       halted,      1'b0);
        check("halt_clr_ready", instr_ready, 1'b1);

        // Opcode 0xC: MUL when enabled, NOP otherwise
        sendByte(8'h80); sendByte(8'h20);
        sendByte(8'h62);
        sendByte(8'h80); sendByte(8'h10);
        sendByte(8'hC2);
        settle();
`ifdef PARAM_ACC_CPU_MUL_EN
        check("mul_acc",   acc_out, 8'h00);
        check("mul_carry", carry,   1'b1);
        check("mul_zero",  zero,    1'b1);
`else
        check("mul_off_acc",   acc_out, 8'h10);
        check("mul_off_carry", carry,   1'b0);
        check("mul_off_zero",  zero,    1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
